// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RV32I-subset core: opcodes, ALU ops,
// pipeline register layouts, and the instruction decode / immediate helpers.
package riscv_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6f;

   localparam logic [2:0] F3_ADD = 3'd0;
   localparam logic [2:0] F3_SLL = 3'd1;
   localparam logic [2:0] F3_SLT = 3'd2;
   localparam logic [2:0] F3_XOR = 3'd4;
   localparam logic [2:0] F3_SR  = 3'd5;
   localparam logic [2:0] F3_OR  = 3'd6;
   localparam logic [2:0] F3_AND = 3'd7;
   localparam logic [2:0] F3_BEQ = 3'd0;
   localparam logic [2:0] F3_BNE = 3'd1;
   localparam logic [2:0] F3_W   = 3'd2;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
   } alu_op_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    use_imm;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    bne;
      logic    jal;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      ctrl_t       ctrl;
   } idex_t;

   localparam idex_t IDEX_NOP = '{32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, CTRL_NOP};

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        we;
      logic        mr;
      logic        mw;
   } exmem_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
   } memwb_t;

   // Unsupported encodings fall out with reg_write/mem_write clear, i.e. as NOPs.
   function automatic ctrl_t decode(input logic [31:0] ins);
      ctrl_t      c;
      logic [2:0] f3;
      logic [6:0] f7;
      c  = CTRL_NOP;
      f3 = ins[14:12];
      f7 = ins[31:25];
      case (ins[6:0])
         OPC_OP: begin
            if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SR))) begin
               c.use_imm   = 1'b0;
               c.reg_write = 1'b1;
               case (f3)
                  F3_ADD:  c.alu_op = f7[5] ? ALU_SUB : ALU_ADD;
                  F3_SLL:  c.alu_op = ALU_SLL;
                  F3_SLT:  c.alu_op = ALU_SLT;
                  F3_XOR:  c.alu_op = ALU_XOR;
                  F3_SR:   c.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                  F3_OR:   c.alu_op = ALU_OR;
                  F3_AND:  c.alu_op = ALU_AND;
                  default: c.reg_write = 1'b0;
               endcase
            end
         end
         OPC_OPIMM: begin
            c.reg_write = 1'b1;
            case (f3)
               F3_ADD: c.alu_op = ALU_ADD;
               F3_SLT: c.alu_op = ALU_SLT;
               F3_XOR: c.alu_op = ALU_XOR;
               F3_OR:  c.alu_op = ALU_OR;
               F3_AND: c.alu_op = ALU_AND;
               F3_SLL: begin
                  if (f7 == 7'h00) c.alu_op = ALU_SLL;
                  else             c.reg_write = 1'b0;
               end
               F3_SR: begin
                  if (f7 == 7'h00)      c.alu_op = ALU_SRL;
                  else if (f7 == 7'h20) c.alu_op = ALU_SRA;
                  else                  c.reg_write = 1'b0;
               end
               default: c.reg_write = 1'b0;
            endcase
         end
         OPC_LUI: begin
            c.alu_op    = ALU_PASSB;
            c.reg_write = 1'b1;
         end
         OPC_LOAD: begin
            if (f3 == F3_W) begin
               c.reg_write = 1'b1;
               c.mem_read  = 1'b1;
            end
         end
         OPC_STORE: begin
            if (f3 == F3_W) c.mem_write = 1'b1;
         end
         OPC_BRANCH: begin
            if (f3 == F3_BEQ || f3 == F3_BNE) begin
               c.branch = 1'b1;
               c.bne    = f3[0];
            end
         end
         OPC_JAL: begin
            c.jal       = 1'b1;
            c.reg_write = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] imm_gen(input logic [31:0] ins);
      case (ins[6:0])
         OPC_OPIMM, OPC_LOAD: return {{20{ins[31]}}, ins[31:20]};
         OPC_STORE:           return {{20{ins[31]}}, ins[31:25], ins[11:7]};
         OPC_BRANCH:          return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         OPC_LUI:             return {ins[31:12], 12'h000};
         OPC_JAL:             return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:             return '0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file, two combinational reads, one synchronous write.
// x0 reads as zero; a same-cycle write is bypassed onto the read ports.
module riscv_regfile (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  ra1_i,
   output logic [31:0] rd1_o,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);

   logic [31:0] regs_q [32];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && wa_i != 5'd0) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   always_comb begin
      rd1_o = regs_q[ra1_i];
      rd2_o = regs_q[ra2_i];
      if (we_i && wa_i != 5'd0 && wa_i == ra1_i) rd1_o = wd_i;
      if (we_i && wa_i != 5'd0 && wa_i == ra2_i) rd2_o = wd_i;
      if (ra1_i == 5'd0) rd1_o = '0;
      if (ra2_i == 5'd0) rd2_o = '0;
   end

endmodule

// File: rtl/riscv_cpu.sv
// 5-stage pipelined RV32I-subset core with EX forwarding, load-use stall and
// branch/JAL resolution in EX. Reset input rst_n is active-high.
module riscv_cpu
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_data,
   input  logic            imem_valid,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_data_write,
   input  logic [XLEN-1:0] dmem_data_read,
   output logic            dmem_write_en
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc_q, ifid_pc_d;
   idex_t       idex_q, idex_d;
   exmem_t      exmem_q, exmem_d;
   memwb_t      memwb_q, memwb_d;

   logic [4:0]  id_rs1, id_rs2;
   logic [31:0] rf_rd1, rf_rd2;
   logic [31:0] fwd_a, fwd_b, op_b, alu_res, target;
   logic        take, load_use;

   assign id_rs1 = ifid_instr_q[19:15];
   assign id_rs2 = ifid_instr_q[24:20];

   riscv_regfile u_regfile (
      .clk_i (clk),
      .rst_i (rst_n),
      .ra1_i (id_rs1),
      .rd1_o (rf_rd1),
      .ra2_i (id_rs2),
      .rd2_o (rf_rd2),
      .we_i  (memwb_q.we),
      .wa_i  (memwb_q.rd),
      .wd_i  (memwb_q.data)
   );

   always_comb begin
      fwd_a = idex_q.a;
      if (exmem_q.we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1)      fwd_a = exmem_q.alu;
      else if (memwb_q.we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) fwd_a = memwb_q.data;
      fwd_b = idex_q.b;
      if (exmem_q.we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2)      fwd_b = exmem_q.alu;
      else if (memwb_q.we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) fwd_b = memwb_q.data;
   end

   always_comb begin
      op_b = idex_q.ctrl.use_imm ? idex_q.imm : fwd_b;
      case (idex_q.ctrl.alu_op)
         ALU_ADD:   alu_res = fwd_a + op_b;
         ALU_SUB:   alu_res = fwd_a - op_b;
         ALU_AND:   alu_res = fwd_a & op_b;
         ALU_OR:    alu_res = fwd_a | op_b;
         ALU_XOR:   alu_res = fwd_a ^ op_b;
         ALU_SLT:   alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
         ALU_SLL:   alu_res = fwd_a << op_b[4:0];
         ALU_SRL:   alu_res = fwd_a >> op_b[4:0];
         ALU_SRA:   alu_res = $signed(fwd_a) >>> op_b[4:0];
         ALU_PASSB: alu_res = op_b;
         default:   alu_res = '0;
      endcase
      take   = idex_q.ctrl.jal | (idex_q.ctrl.branch & ((fwd_a == fwd_b) ^ idex_q.ctrl.bne));
      target = idex_q.pc + idex_q.imm;
   end

   assign load_use = idex_q.ctrl.mem_read && idex_q.rd != 5'd0 &&
                     (idex_q.rd == id_rs1 || idex_q.rd == id_rs2);

   // Fetch priority: taken redirect, then load-use hold, then imem_valid.
   always_comb begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      if (take) begin
         pc_d         = target;
         ifid_instr_d = NOP_INSTR;
      end else if (!load_use) begin
         if (imem_valid) begin
            pc_d         = pc_q + 32'd4;
            ifid_instr_d = imem_data;
            ifid_pc_d    = pc_q;
         end else begin
            ifid_instr_d = NOP_INSTR;
         end
      end

      idex_d      = IDEX_NOP;
      if (!take && !load_use) begin
         idex_d.pc   = ifid_pc_q;
         idex_d.rs1  = id_rs1;
         idex_d.rs2  = id_rs2;
         idex_d.rd   = ifid_instr_q[11:7];
         idex_d.a    = rf_rd1;
         idex_d.b    = rf_rd2;
         idex_d.imm  = imm_gen(ifid_instr_q);
         idex_d.ctrl = decode(ifid_instr_q);
      end

      exmem_d.alu   = idex_q.ctrl.jal ? idex_q.pc + 32'd4 : alu_res;
      exmem_d.store = fwd_b;
      exmem_d.rd    = idex_q.rd;
      exmem_d.we    = idex_q.ctrl.reg_write;
      exmem_d.mr    = idex_q.ctrl.mem_read;
      exmem_d.mw    = idex_q.ctrl.mem_write;

      memwb_d.data  = exmem_q.mr ? dmem_data_read : exmem_q.alu;
      memwb_d.rd    = exmem_q.rd;
      memwb_d.we    = exmem_q.we;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= '0;
         idex_q       <= IDEX_NOP;
         exmem_q      <= '0;
         memwb_q      <= '0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         idex_q       <= idex_d;
         exmem_q      <= exmem_d;
         memwb_q      <= memwb_d;
      end
   end

   assign imem_addr       = pc_q;
   assign dmem_addr       = exmem_q.alu;
   assign dmem_data_write = exmem_q.store;
   assign dmem_write_en   = exmem_q.mw;

endmodule

// File: tb/tb_riscv_cpu.sv
// Directed-program bench for riscv_cpu: stores are scored against a queue of
// hand-computed (addr, data, cycle) entries; fetch addresses checked per cycle.
module tb_riscv_cpu;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_valid = 1'b1;
   logic [31:0] imem_addr, imem_data, dmem_addr, dmem_data_write, dmem_data_read;
   logic        dmem_write_en;

   logic [31:0] imem [64];
   logic [31:0] dmem [64];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } st_t;

   st_t         exp_q[$];
   logic [31:0] exp_pc[int];
   int          checks = 0;
   int          errors = 0;
   int          cyc;
   int          gap_lo = -1;
   int          gap_hi = -1;

   riscv_cpu #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .imem_valid      (imem_valid),
      .dmem_addr       (dmem_addr),
      .dmem_data_write (dmem_data_write),
      .dmem_data_read  (dmem_data_read),
      .dmem_write_en   (dmem_write_en)
   );

   always #5 clk = ~clk;

   assign imem_data      = imem[imem_addr[7:2]];
   assign dmem_data_read = dmem[dmem_addr[7:2]];

   always @(posedge clk) if (dmem_write_en === 1'b1) dmem[dmem_addr[7:2]] <= dmem_data_write;

   always @(posedge clk or posedge rst_n) begin
      if (rst_n) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Store monitor / scoreboard
   always @(negedge clk) begin
      st_t e;
      if (!rst_n && dmem_write_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_store actual addr=%h data=%h cyc=%0d required none",
                     dmem_addr, dmem_data_write, cyc);
         end else begin
            e = exp_q.pop_front();
            if (dmem_addr !== e.addr || dmem_data_write !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL store actual addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                        dmem_addr, dmem_data_write, cyc, e.addr, e.data, e.cyc);
            end
         end
      end
   end

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [11:0] imm,
                                          input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [12:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
      return enc_i(imm, rs1, 3'd0, rd, 7'h13);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic exp_st(input logic [31:0] a, input logic [31:0] d, input int c);
      st_t e;
      e.addr = a;
      e.data = d;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic new_prog();
      for (int i = 0; i < 64; i++) imem[i] = NOP;
      exp_q.delete();
      exp_pc.delete();
      gap_lo = -1;
      gap_hi = -1;
   endtask

   task automatic load_fwd_prog();
      imem[0] = addi(5'd1, 5'd0, 12'd5);
      imem[1] = addi(5'd2, 5'd1, 12'd3);
      imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
      imem[3] = enc_sw(5'd3, 12'd0, 5'd0);
   endtask

   task automatic run_prog(input string tag, input int ncyc);
      rst_n      = 1'b1;
      imem_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk({tag, "_rst_imem_addr"}, imem_addr, 32'h0);
      chk({tag, "_rst_dmem_we"}, {31'd0, dmem_write_en}, 32'h0);
      chk({tag, "_rst_dmem_addr"}, dmem_addr, 32'h0);
      chk({tag, "_rst_dmem_wdata"}, dmem_data_write, 32'h0);
      rst_n = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) @(negedge clk);
         imem_valid = !(c >= gap_lo && c <= gap_hi);
         if (exp_pc.exists(c)) chk($sformatf("%s_imem_addr_c%0d", tag, c), imem_addr, exp_pc[c]);
      end
      chk({tag, "_pending_stores"}, exp_q.size(), 32'h0);
   endtask

   initial begin
      // Forwarding chain, no stalls
      new_prog();
      load_fwd_prog();
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hc;
      exp_st(32'h0, 32'd13, 6);
      run_prog("fwd", 10);

      // Same program, reset lands before the store reaches MEM
      new_prog();
      load_fwd_prog();
      run_prog("abort", 5);

      // Load-use: one bubble before the dependent addi
      new_prog();
      imem[0] = addi(5'd1, 5'd0, 12'd7);
      imem[1] = enc_sw(5'd1, 12'd4, 5'd0);
      imem[2] = enc_i(12'd4, 5'd0, 3'd2, 5'd4, 7'h03);
      imem[3] = addi(5'd5, 5'd4, 12'd1);
      imem[4] = enc_sw(5'd5, 12'd8, 5'd0);
      exp_pc[4] = 32'h10; exp_pc[5] = 32'h10; exp_pc[6] = 32'h14;
      exp_st(32'h4, 32'd7, 4);
      exp_st(32'h8, 32'd8, 8);
      run_prog("ldu", 12);

      // Taken BEQ flushes the addi behind it
      new_prog();
      imem[0] = addi(5'd1, 5'd0, 12'd1);
      imem[1] = enc_b(3'd0, 5'd1, 5'd1, 13'd8);
      imem[2] = addi(5'd6, 5'd0, 12'd9);
      imem[3] = enc_sw(5'd6, 12'd12, 5'd0);
      exp_pc[3] = 32'hc; exp_pc[4] = 32'hc; exp_pc[5] = 32'h10;
      exp_st(32'hc, 32'd0, 7);
      run_prog("beq", 12);

      // Fetch gap of three cycles
      new_prog();
      load_fwd_prog();
      gap_lo = 2;
      gap_hi = 4;
      exp_pc[2] = 32'h8; exp_pc[3] = 32'h8; exp_pc[4] = 32'h8; exp_pc[5] = 32'h8; exp_pc[6] = 32'hc;
      exp_st(32'h0, 32'd13, 9);
      run_prog("gap", 14);

      // x0 write ignored; JAL at 0x20 links 0x24 and redirects to 0x30
      new_prog();
      imem[0]  = addi(5'd0, 5'd0, 12'd5);
      imem[1]  = enc_sw(5'd0, 12'd16, 5'd0);
      imem[8]  = enc_jal(5'd1, 21'd16);
      imem[9]  = addi(5'd7, 5'd0, 12'd1);
      imem[10] = addi(5'd7, 5'd0, 12'd2);
      imem[12] = enc_sw(5'd1, 12'd20, 5'd0);
      imem[13] = enc_sw(5'd7, 12'd24, 5'd0);
      exp_pc[10] = 32'h28; exp_pc[11] = 32'h30; exp_pc[12] = 32'h34;
      exp_st(32'h10, 32'd0, 4);
      exp_st(32'h14, 32'h24, 14);
      exp_st(32'h18, 32'd0, 15);
      run_prog("jal", 20);

      // ALU mix, LUI, shifts, SLT, not-taken BNE
      new_prog();
      imem[0]  = {20'h80000, 5'd1, 7'h37};
      imem[1]  = addi(5'd2, 5'd0, 12'hffd);
      imem[2]  = enc_i(12'h404, 5'd1, 3'd5, 5'd3, 7'h13);
      imem[3]  = enc_i(12'h004, 5'd1, 3'd5, 5'd4, 7'h13);
      imem[4]  = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd5);
      imem[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd6);
      imem[6]  = enc_i(12'h0ff, 5'd2, 3'd4, 5'd7, 7'h13);
      imem[7]  = enc_sw(5'd3, 12'd0, 5'd0);
      imem[8]  = enc_sw(5'd4, 12'd4, 5'd0);
      imem[9]  = enc_sw(5'd5, 12'd8, 5'd0);
      imem[10] = enc_sw(5'd6, 12'd12, 5'd0);
      imem[11] = enc_sw(5'd7, 12'd16, 5'd0);
      imem[12] = enc_b(3'd1, 5'd1, 5'd1, 13'd8);
      imem[13] = enc_i(12'h01f, 5'd2, 3'd1, 5'd8, 7'h13);
      imem[14] = enc_sw(5'd8, 12'd20, 5'd0);
      imem[15] = enc_r(7'h00, 5'd7, 5'd2, 3'd7, 5'd9);
      imem[16] = enc_r(7'h00, 5'd6, 5'd4, 3'd6, 5'd10);
      imem[17] = enc_sw(5'd9, 12'd24, 5'd0);
      imem[18] = enc_sw(5'd10, 12'd28, 5'd0);
      exp_st(32'h00, 32'hf800_0000, 10);
      exp_st(32'h04, 32'h0800_0000, 11);
      exp_st(32'h08, 32'h7fff_fffd, 12);
      exp_st(32'h0c, 32'h0000_0001, 13);
      exp_st(32'h10, 32'hffff_ff02, 14);
      exp_st(32'h14, 32'h8000_0000, 17);
      exp_st(32'h18, 32'hffff_ff00, 20);
      exp_st(32'h1c, 32'h0800_0001, 21);
      run_prog("alu", 26);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
